// File: rtl/scrambler_pipe.sv
// scrambler_pipe: two-stage additive scrambler/descrambler for DATA_BYTES bytes
// per beat, using the x^16+x^5+x^4+x^3+1 Galois LFSR. K-characters are never
// altered. COM reseeds the LFSR, SKP freezes it, and other K-codes advance it.
// Optional build macro SCRAM_LFSR_OBS_EN adds the lfsr_state and com_seen
// observation ports.
//
// Handshake: a beat moves on an edge where valid && ready. Both pipeline
// stages and the LFSR advance together only when adv = !out_valid || out_ready,
// and in_ready is adv. While out_valid=1 and out_ready=0, every output and the
// LFSR hold.
module scrambler_pipe #(
    parameter int          DATA_BYTES = 2,
    parameter logic [15:0] SEED       = 16'hFFFF,
    parameter logic [15:0] POLY       = 16'h0039,
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  SKP_SYM    = 8'h1C
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      scram_en,
    input  logic                      scram_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*DATA_BYTES-1:0]   in_data,
    input  logic [DATA_BYTES-1:0]     in_k,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8*DATA_BYTES-1:0]   out_data,
    output logic [DATA_BYTES-1:0]     out_k
`ifdef SCRAM_LFSR_OBS_EN
    ,
    output logic [15:0]               lfsr_state,
    output logic                      com_seen
`endif
);

    localparam int W = 8 * DATA_BYTES;

    logic            adv;
    logic            s1_valid_q;
    logic [W-1:0]    s1_data_q;
    logic [DATA_BYTES-1:0] s1_k_q;
    logic            s1_en_q;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [DATA_BYTES-1:0] out_k_q;
    logic [15:0]     lfsr_q;
    logic [15:0]     lfsr_d;
    logic [W-1:0]    out_data_d;
    logic [7:0]      byte_v;
`ifdef SCRAM_LFSR_OBS_EN
    logic            com_d;
    logic            out_com_q;
    logic            com_seen_q;
`endif

    // One Galois step; the bit shifted out of bit 15 is the keystream bit.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000);
    endfunction

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_k     = out_k_q;

    // Walk the stage-1 bytes in order, chaining the LFSR state byte to byte.
    always_comb begin
        lfsr_d     = lfsr_q;
        out_data_d = s1_data_q;
        byte_v     = 8'h00;
`ifdef SCRAM_LFSR_OBS_EN
        com_d      = 1'b0;
`endif
        for (int b = 0; b < DATA_BYTES; b++) begin
            byte_v = s1_data_q[8*b +: 8];
            if (s1_k_q[b] && (byte_v == COM_SYM)) begin
                // COM reseeds even in bypass; the following byte uses SEED.
                lfsr_d = SEED;
`ifdef SCRAM_LFSR_OBS_EN
                com_d  = 1'b1;
`endif
            end else if (s1_en_q) begin
                if (!s1_k_q[b]) begin
                    for (int i = 0; i < 8; i++) begin
                        byte_v[i] = byte_v[i] ^ lfsr_d[15];
                        lfsr_d    = lfsr_step(lfsr_d);
                    end
                end else if (byte_v != SKP_SYM) begin
                    for (int i = 0; i < 8; i++) begin
                        lfsr_d = lfsr_step(lfsr_d);
                    end
                end
            end
            out_data_d[8*b +: 8] = byte_v;
        end
    end

    // Stage 1: capture the incoming beat and its per-beat scramble enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_k_q     <= '0;
            s1_en_q    <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_k_q    <= in_k;
                s1_en_q   <= scram_en;
            end
        end
    end

    // Stage 2: register the processed bytes and the matching K flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_k_q     <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_k_q    <= s1_k_q;
            end
        end
    end

    // LFSR: scram_rst wins over the advance; the beat moving on the same edge
    // has already been processed with the pre-reload state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (scram_rst) begin
            lfsr_q <= SEED;
        end else if (s1_valid_q && adv) begin
            lfsr_q <= lfsr_d;
        end
    end

`ifdef SCRAM_LFSR_OBS_EN
    // Observation: flag COM beats in stage 2 and pulse when one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_com_q  <= 1'b0;
            com_seen_q <= 1'b0;
        end else begin
            com_seen_q <= out_valid_q && out_ready && out_com_q;
            if (adv && s1_valid_q) begin
                out_com_q <= com_d;
            end
        end
    end

    assign lfsr_state = lfsr_q;
    assign com_seen   = com_seen_q;
`endif

endmodule

// File: tb/tb_scrambler_pipe.sv
// tb_scrambler_pipe: directed table, randomized scoreboard, stall, reset and
// loop-back checks for scrambler_pipe (DATA_BYTES=2).
module tb_scrambler_pipe;

  localparam int DB = 2;
  localparam int W  = 16;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam int KS_LEN = 65536;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic scram_en, scram_rst, in_valid;
  logic [W-1:0] in_data;
  logic [DB-1:0] in_k;
  logic tb_out_ready, loop_mode, d2_out_ready, rand_bp;

  logic in_ready, out_valid, dut_out_ready;
  logic [W-1:0] out_data;
  logic [DB-1:0] out_k;
  logic d2_in_ready, d2_in_valid, d2_out_valid;
  logic [W-1:0] d2_out_data;
  logic [DB-1:0] d2_out_k;
`ifdef SCRAM_LFSR_OBS_EN
  logic [15:0] lfsr_state, d2_lfsr_state;
  logic com_seen, d2_com_seen;
`endif

  always #5 clk = ~clk;

  assign dut_out_ready = loop_mode ? d2_in_ready : tb_out_ready;
  assign d2_in_valid   = out_valid & loop_mode;

  scrambler_pipe dut (
    .clk(clk), .rst_n(rst_n), .scram_en(scram_en), .scram_rst(scram_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
    .out_valid(out_valid), .out_ready(dut_out_ready), .out_data(out_data), .out_k(out_k)
`ifdef SCRAM_LFSR_OBS_EN
    , .lfsr_state(lfsr_state), .com_seen(com_seen)
`endif
  );

  scrambler_pipe dut2 (
    .clk(clk), .rst_n(rst_n), .scram_en(1'b1), .scram_rst(1'b0),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(out_data), .in_k(out_k),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data), .out_k(d2_out_k)
`ifdef SCRAM_LFSR_OBS_EN
    , .lfsr_state(d2_lfsr_state), .com_seen(d2_com_seen)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic [DB-1:0] expk_q[$];
  logic [W-1:0]  lb_q[$];
  logic [DB-1:0] lbk_q[$];

  // Reference: keystream bit n is the LFSR output n steps after SEED; the
  // model state is just the position in that stream.
  bit ks[KS_LEN];
  int m_pos;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic gen_keystream();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int n = 0; n < KS_LEN; n++) begin
      ks[n] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    end
  endtask

  function automatic logic [15:0] state_at(input int pos);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int n = 0; n < pos; n++) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    return s;
  endfunction

  task automatic model_beat(input logic [W-1:0] d, input logic [DB-1:0] k,
                            input logic en, output logic [W-1:0] r);
    logic [7:0] by;
    r = d;
    for (int b = 0; b < DB; b++) begin
      by = d[8*b +: 8];
      if (k[b] && by == COM) m_pos = 0;
      else if (en) begin
        if (!k[b]) begin
          for (int i = 0; i < 8; i++) by[i] = by[i] ^ ks[(m_pos + i) % KS_LEN];
          m_pos += 8;
        end else if (by != SKP) m_pos += 8;
      end
      r[8*b +: 8] = by;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic [DB-1:0] k, input logic en,
                      input bit use_exp, input logic [W-1:0] exp_d);
    logic [W-1:0] r;
    int guard;
    in_valid = 1'b1; in_data = d; in_k = k; scram_en = en;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin guard++; @(negedge clk); end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_beat(d, k, en, r);
    exp_q.push_back(use_exp ? exp_d : r);
    expk_q.push_back(k);
    if (loop_mode) begin lb_q.push_back(d); lbk_q.push_back(k); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_beat(output logic [W-1:0] d, output logic [DB-1:0] k);
    logic [7:0] kc[5];
    int r;
    kc[0] = 8'hF7; kc[1] = 8'hFB; kc[2] = 8'hFD; kc[3] = 8'hFE; kc[4] = 8'h3C;
    for (int b = 0; b < DB; b++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin d[8*b +: 8] = COM; k[b] = 1'b1; end
      else if (r == 1) begin d[8*b +: 8] = SKP; k[b] = 1'b1; end
      else if (r == 2) begin d[8*b +: 8] = kc[$urandom_range(0, 4)]; k[b] = 1'b1; end
      else begin d[8*b +: 8] = 8'($urandom_range(0, 255)); k[b] = 1'b0; end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || lb_q.size() != 0) && guard < 2000) begin
      @(posedge clk); guard++;
    end
    check("drain_leftover", 64'(exp_q.size() + lb_q.size()), 0);
    idle(2);
  endtask

  // ---------------- monitors / scoreboard ----------------
  logic          prev_stall;
  logic [W-1:0]  prev_d;
  logic [DB-1:0] prev_k;

  initial begin
    prev_stall = 1'b0; prev_d = '0; prev_k = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_stall = 1'b0; continue; end
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_d);
        check("stall_k_hold", out_k, prev_k);
      end
      if (out_valid && !dut_out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && dut_out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", out_data, 64'hDEAD_BEEF);
        else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_k", out_k, expk_q.pop_front());
        end
      end
      prev_stall = out_valid && !dut_out_ready;
      prev_d = out_data; prev_k = out_k;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && d2_out_valid && d2_out_ready) begin
        if (lb_q.size() == 0) check("loop_spurious", d2_out_data, 64'hDEAD_BEEF);
        else begin
          check("loop_data", d2_out_data, lb_q.pop_front());
          check("loop_k", d2_out_k, lbk_q.pop_front());
        end
      end
    end
  end

  // Random backpressure on both consumers.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) begin
        tb_out_ready = ($urandom_range(0, 3) != 0);
        d2_out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [DB-1:0] k;
    logic [W-1:0]  d;
    logic          en;
    logic [W-1:0]  exp_d;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [W-1:0] d;
    logic [DB-1:0] k;

    tbl[0]  = '{2'b11, 16'hBCBC, 1'b1, 16'hBCBC};
    tbl[1]  = '{2'b00, 16'h0000, 1'b1, 16'h17FF};
    tbl[2]  = '{2'b11, 16'hBCBC, 1'b1, 16'hBCBC};
    tbl[3]  = '{2'b11, 16'h1C1C, 1'b1, 16'h1C1C};
    tbl[4]  = '{2'b00, 16'h0000, 1'b1, 16'h17FF};
    tbl[5]  = '{2'b01, 16'h00BC, 1'b1, 16'hFFBC};
    tbl[6]  = '{2'b00, 16'h0000, 1'b1, 16'hC017};
    tbl[7]  = '{2'b11, 16'hBCBC, 1'b0, 16'hBCBC};
    tbl[8]  = '{2'b00, 16'h1234, 1'b0, 16'h1234};
    tbl[9]  = '{2'b00, 16'h0000, 1'b1, 16'h17FF};
    tbl[10] = '{2'b11, 16'hBCBC, 1'b1, 16'hBCBC};
    tbl[11] = '{2'b10, 16'hF700, 1'b1, 16'hF7FF};
    tbl[12] = '{2'b00, 16'h0000, 1'b0, 16'h0000};
    tbl[13] = '{2'b11, 16'h1CBC, 1'b1, 16'h1CBC};
    tbl[14] = '{2'b00, 16'h0000, 1'b1, 16'h17FF};

    rst_n = 1'b0; scram_en = 1'b0; scram_rst = 1'b0; in_valid = 1'b0;
    in_data = '0; in_k = '0; tb_out_ready = 1'b1; loop_mode = 1'b0;
    d2_out_ready = 1'b1; rand_bp = 1'b0;
    gen_keystream();
    m_pos = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_k", out_k, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
`ifdef SCRAM_LFSR_OBS_EN
    check("rst_lfsr_state", lfsr_state, 16'hFFFF);
    check("rst_com_seen", com_seen, 0);
`endif

    // Latency: zero beat from SEED, visible after the second edge
    send(16'h0000, 2'b00, 1'b1, 1'b1, 16'h17FF);
    check("lat_edge1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", out_valid, 1);
    check("lat_edge2_data", out_data, 16'h17FF);

    // Directed table, back-to-back
    for (int i = 0; i < 15; i++) send(tbl[i].d, tbl[i].k, tbl[i].en, 1'b1, tbl[i].exp_d);
    idle(4);

    // Bypass with random data: passes straight through, LFSR untouched
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom_range(0, 65535));
      send(d, 2'b00, 1'b0, 1'b1, d);
    end
    idle(4);
`ifdef SCRAM_LFSR_OBS_EN
    check("bypass_lfsr_state", lfsr_state, state_at(m_pos));
`endif

    // scram_rst while idle, then a zero beat starts from SEED
    for (int i = 0; i < 3; i++) send(16'h0000, 2'b00, 1'b1, 1'b0, 16'h0);
    idle(4);
    scram_rst = 1'b1;
    @(posedge clk); #1;
    scram_rst = 1'b0;
    m_pos = 0;
    send(16'h0000, 2'b00, 1'b1, 1'b1, 16'h17FF);
    idle(3);

    // scram_rst on the edge a beat moves to stage 2: that beat uses old state
    send(16'h0000, 2'b00, 1'b1, 1'b0, 16'h0);
    scram_rst = 1'b1;
    m_pos = 0;
    send(16'h0000, 2'b00, 1'b1, 1'b1, 16'h17FF);
    scram_rst = 1'b0;
    idle(4);

    // Stream 8 beats with a 3-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rand_beat(d, k);
          send(d, k, 1'b1, 1'b0, 16'h0);
        end
      end
      begin
        idle(3);
        tb_out_ready = 1'b0;
        idle(3);
        tb_out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with gaps, random enable and backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_beat(d, k);
      send(d, k, ($urandom_range(0, 4) != 0), 1'b0, 16'h0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_bp = 1'b0;
    tb_out_ready = 1'b1;
    d2_out_ready = 1'b1;
    drain();

    // Mid-stream reset with a stalled, full pipeline
    tb_out_ready = 1'b0;
    send(16'h1111, 2'b00, 1'b1, 1'b0, 16'h0);
    send(16'h2222, 2'b00, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_k", out_k, 0);
    exp_q.delete(); expk_q.delete();
    m_pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_beat1", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("midrst_no_beat2", out_valid, 0);
    send(16'hBCBC, 2'b11, 1'b1, 1'b1, 16'hBCBC);
    send(16'h0000, 2'b00, 1'b1, 1'b1, 16'h17FF);
    drain();

    // Loop-back through a second instance: original data must come back
    loop_mode = 1'b1;
    rand_bp = 1'b1;
    send(16'hBCBC, 2'b11, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 1000; i++) begin
      rand_beat(d, k);
      send(d, k, 1'b1, 1'b0, 16'h0);
    end
    rand_bp = 1'b0;
    d2_out_ready = 1'b1;
    drain();
    loop_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
